// File: rtl/watch_pkg.sv
// Shared types and defaults for the watch display path.
package watch_pkg;

    localparam int DIGIT_W_DEF    = 4;
    localparam int BLANK_CODE_DEF = 10;

    typedef enum logic {
        IDLE  = 1'b0,
        BLINK = 1'b1
    } state_t;

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector for a level input that is already synchronous to uclock.
// A level that is high when reset is released becomes the baseline, so a
// button held through reset does not register as a press.
module rise_edge_det (
    input  logic uclock,
    input  logic reset,
    input  logic d,
    output logic pulse
);

    logic prev;
    logic armed;

    // History register; armed goes high after the first sample following reset.
    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= d;
            armed <= 1'b1;
        end
    end

    assign pulse = d & ~prev & armed;

endmodule

// File: rtl/digit_blink_ctrl.sv
// Display-blanking controller for time/alarm set mode.
// Passes digits through when idle; in blink mode it periodically blanks the
// selected field or every digit.
//
// state | meaning
// IDLE  | pass-through, counter held at 0
// BLINK | blank phase at the start of each period on field_sel or all digits
module digit_blink_ctrl
    import watch_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_W      = DIGIT_W_DEF,
    parameter int FIELD_DIGITS = 2,
    parameter int PERIOD       = 25_000_000,
    parameter int BLANK_CYCLES = 5_500_000,
    parameter int BLANK_CODE   = BLANK_CODE_DEF,
    localparam int NUM_FIELDS  = NUM_DIGITS / FIELD_DIGITS,
    localparam int FSEL_W      = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
    input  logic                          uclock,
    input  logic                          reset,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] num,
    input  logic                          toggle_btn,
    input  logic                          inhibit,
    input  logic                          sel_next,
    input  logic                          blink_all,
    output logic [NUM_DIGITS*DIGIT_W-1:0] pnum,
    output logic                          blink_active,
    output logic [FSEL_W-1:0]             field_sel
);

    localparam int CNT_W = $clog2(PERIOD);
    localparam logic [CNT_W-1:0]   PERIOD_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]   BLANK_LIM   = CNT_W'(BLANK_CYCLES);
    localparam logic [FSEL_W-1:0]  FIELD_LAST  = FSEL_W'(NUM_FIELDS - 1);
    localparam logic [DIGIT_W-1:0] DARK        = DIGIT_W'(BLANK_CODE);

    state_t                        state;
    logic [CNT_W-1:0]              counter;
    logic                          tog_pulse;
    logic                          sel_pulse;
    logic                          blank_phase;
    logic [NUM_DIGITS*DIGIT_W-1:0] disp;

    rise_edge_det u_tog_edge (
        .uclock (uclock),
        .reset  (reset),
        .d      (toggle_btn),
        .pulse  (tog_pulse)
    );

    rise_edge_det u_sel_edge (
        .uclock (uclock),
        .reset  (reset),
        .d      (sel_next),
        .pulse  (sel_pulse)
    );

    assign blank_phase = (counter < BLANK_LIM);

    // Blink-mode view of the digits: dark code on blanked digits during the blank phase.
    always_comb begin
        disp = num;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (blank_phase && (blink_all || field_sel == FSEL_W'(i / FIELD_DIGITS))) begin
                disp[i*DIGIT_W +: DIGIT_W] = DARK;
            end
        end
    end

    // Mode FSM with registered display, status, field selection and blink counter.
    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            blink_active <= 1'b0;
            field_sel    <= '0;
            counter      <= '0;
            pnum         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pnum    <= num;
                    counter <= '0;
                    if (tog_pulse && !inhibit) begin
                        state        <= BLINK;
                        blink_active <= 1'b1;
                        field_sel    <= '0;
                    end
                end
                BLINK: begin
                    pnum <= disp;
                    if (tog_pulse && !inhibit) begin
                        // Toggle wins over a coincident sel_next edge.
                        state        <= IDLE;
                        blink_active <= 1'b0;
                        counter      <= '0;
                    end else if (sel_pulse) begin
                        // Restart the period so the new field blanks at once.
                        field_sel <= (field_sel == FIELD_LAST) ? '0 : field_sel + 1'b1;
                        counter   <= '0;
                    end else if (counter == PERIOD_LAST) begin
                        counter <= '0;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    blink_active <= 1'b0;
                    counter      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_blink_ctrl.sv
// Self-checking bench for digit_blink_ctrl against a behavioural model.
module tb_digit_blink_ctrl;

    localparam int ND = 4;
    localparam int DW = 4;
    localparam int FD = 2;
    localparam int NF = ND / FD;
    localparam int P  = 10;
    localparam int B  = 3;

    logic          uclock;
    logic          reset;
    logic [15:0]   num;
    logic          toggle_btn;
    logic          inhibit;
    logic          sel_next;
    logic          blink_all;
    logic [15:0]   pnum;
    logic          blink_active;
    logic [0:0]    field_sel;

    int n_chk;
    int n_fail;

    // model state
    bit          m_mode;
    int          m_field;
    int          m_elapsed;
    bit          m_tprev;
    bit          m_sprev;
    bit          m_armed;
    logic [15:0] exp_pnum;
    bit          chk_en;

    digit_blink_ctrl #(
        .NUM_DIGITS   (ND),
        .DIGIT_W      (DW),
        .FIELD_DIGITS (FD),
        .PERIOD       (P),
        .BLANK_CYCLES (B),
        .BLANK_CODE   (10)
    ) dut (
        .uclock       (uclock),
        .reset        (reset),
        .num          (num),
        .toggle_btn   (toggle_btn),
        .inhibit      (inhibit),
        .sel_next     (sel_next),
        .blink_all    (blink_all),
        .pnum         (pnum),
        .blink_active (blink_active),
        .field_sel    (field_sel)
    );

    initial begin
        uclock = 1'b0;
        forever #5 uclock = ~uclock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] shown(input logic [15:0] n, input bit blank,
                                          input bit all, input int field);
        logic [15:0] r;
        r = n;
        for (int d = 0; d < ND; d++) begin
            if (blank && (all || (d / FD) == field)) r[d*DW +: DW] = 4'd10;
        end
        return r;
    endfunction

    // Reference model: elapsed cycles since the last period restart decide the blank phase.
    always @(posedge uclock or posedge reset) begin
        if (reset) begin
            m_mode    = 1'b0;
            m_field   = 0;
            m_elapsed = 0;
            m_tprev   = 1'b0;
            m_sprev   = 1'b0;
            m_armed   = 1'b0;
            exp_pnum  = '0;
        end else begin
            bit t_edge;
            bit s_edge;
            t_edge = m_armed && toggle_btn && !m_tprev;
            s_edge = m_armed && sel_next && !m_sprev;
            exp_pnum = m_mode ? shown(num, (m_elapsed % P) < B, blink_all, m_field) : num;
            if (t_edge && !inhibit) begin
                m_mode    = !m_mode;
                m_elapsed = 0;
                if (m_mode) m_field = 0;
            end else if (m_mode && s_edge) begin
                m_field   = (m_field + 1) % NF;
                m_elapsed = 0;
            end else if (m_mode) begin
                m_elapsed++;
            end
            m_tprev = toggle_btn;
            m_sprev = sel_next;
            m_armed = 1'b1;
        end
    end

    // Compare outputs against the model between clock edges.
    always @(negedge uclock) begin
        if (chk_en && !reset) begin
            chk("pnum", 32'(pnum), 32'(exp_pnum));
            chk("blink_active", 32'(blink_active), 32'(m_mode));
            chk("field_sel", 32'(field_sel), 32'(m_field));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge uclock);
    endtask

    task automatic press_toggle();
        @(negedge uclock) toggle_btn = 1'b1;
        @(negedge uclock) toggle_btn = 1'b0;
    endtask

    task automatic press_sel();
        @(negedge uclock) sel_next = 1'b1;
        @(negedge uclock) sel_next = 1'b0;
    endtask

    initial begin
        bit found;
        n_chk      = 0;
        n_fail     = 0;
        chk_en     = 1'b0;
        reset      = 1'b0;
        num        = 16'h4321;
        toggle_btn = 1'b0;
        inhibit    = 1'b0;
        sel_next   = 1'b0;
        blink_all  = 1'b0;
        #1 reset = 1'b1;
        #6;
        chk("rst_pnum", 32'(pnum), 32'h0);
        chk("rst_blink", 32'(blink_active), 32'h0);
        chk("rst_field", 32'(field_sel), 32'h0);
        chk_en = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);

        num = 16'h8765;
        cyc(3);
        chk("idle_pass", 32'(pnum), 32'h8765);
        num = 16'h4321;
        cyc(2);

        press_toggle();
        cyc(25);

        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_elapsed % P == 6) found = 1'b1;
            else @(negedge uclock);
        end
        press_sel();
        cyc(12);
        press_sel();
        cyc(12);

        blink_all = 1'b1;
        cyc(25);
        blink_all = 1'b0;

        inhibit = 1'b1;
        press_toggle();
        inhibit = 1'b0;
        cyc(3);
        chk("inhibit_hold", 32'(blink_active), 32'h1);

        press_sel();
        cyc(2);
        @(negedge uclock) begin toggle_btn = 1'b1; sel_next = 1'b1; end
        @(negedge uclock) begin toggle_btn = 1'b0; sel_next = 1'b0; end
        chk("tog_sel_exit", 32'(blink_active), 32'h0);
        chk("tog_sel_field", 32'(field_sel), 32'h1);
        cyc(3);

        for (int c = 0; c < 1500; c++) begin
            @(negedge uclock);
            if ($urandom % 8 == 0)  toggle_btn = ~toggle_btn;
            if ($urandom % 6 == 0)  sel_next   = ~sel_next;
            if ($urandom % 16 == 0) inhibit    = ~inhibit;
            if ($urandom % 20 == 0) blink_all  = ~blink_all;
            if ($urandom % 10 == 0) num        = 16'($urandom);
        end

        @(negedge uclock) begin toggle_btn = 1'b0; sel_next = 1'b0; inhibit = 1'b0; end
        cyc(2);
        if (!m_mode) press_toggle();
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (m_mode && (m_elapsed % P) >= 1 && (m_elapsed % P) < B) found = 1'b1;
            else @(negedge uclock);
        end
        chk("wait_blank", 32'(found), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_pnum", 32'(pnum), 32'h0);
        chk("midrst_blink", 32'(blink_active), 32'h0);
        toggle_btn = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(6);
        chk("held_no_blink", 32'(blink_active), 32'h0);
        toggle_btn = 1'b0;
        cyc(2);
        press_toggle();
        cyc(1);
        chk("repress_blink", 32'(blink_active), 32'h1);
        cyc(10);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
